cdb_arbiter: RTL

//  Shares the single common data bus (CDB) between NUM_FU functional units that complete out of order.

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_arbiter_rr.sv | 31 +++
 rtl/cdb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB packet types and widths (package sys_defs)
`ifndef ROB_TAG_WIDTH
`define ROB_TAG_WIDTH 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

    localparam int ROB_TAG_W = `ROB_TAG_WIDTH;
    localparam int XLEN_W    = `XLEN;

    // One broadcast as seen by the ROB, reservation stations and map table.
    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN_W-1:0]    v;
    } CDB_ROB_PACKET;

    // One functional unit's pending writeback request.
    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN_W-1:0]    value;
    } FU_CDB_REQ;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// rtl/cdb_arbiter_rr.sv - combinational one-hot round-robin picker (module rr_arbiter)
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int cand;

    // Scan from ptr upward with wraparound; the first requester found wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!grant_valid && req[IDX_W'(cand)]) begin
                grant_valid           = 1'b1;
                grant[IDX_W'(cand)]   = 1'b1;
                grant_idx             = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter; optional stats under CDB_ARB_STATS_EN
import sys_defs::*;

module cdb_arbiter #(
    parameter  int NUM_FU = 4,
    parameter  int TAG_W  = ROB_TAG_W,
    parameter  int DATA_W = XLEN_W,
    parameter  int CNT_W  = 16,
    localparam int IDX_W  = $clog2(NUM_FU)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_FU-1:0]              fu_req,
    input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_rob_tag,
    input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_value,
    output logic [NUM_FU-1:0]              fu_grant,
    input  logic                           squash,
    output logic                           cdb_valid,
    output logic [TAG_W-1:0]               cdb_rob_tag,
    output logic [DATA_W-1:0]              cdb_value,
    output logic [IDX_W-1:0]               cdb_fu_idx,
    output logic [NUM_FU-1:0][CNT_W-1:0]   grant_count,
    output logic [CNT_W-1:0]               conflict_count
);

    logic [IDX_W-1:0]  rr_ptr;
    logic [NUM_FU-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic              grant_fire;

    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req         (fu_req),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // No grant leaves the arbiter while reset is held or the pipeline is flushing.
    assign grant_fire = reset && !squash && arb_valid;
    assign fu_grant   = grant_fire ? arb_grant : '0;

    // Latch the winner onto the CDB one cycle later and advance the pointer past it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid   <= 1'b0;
            cdb_rob_tag <= '0;
            cdb_value   <= '0;
            cdb_fu_idx  <= '0;
            rr_ptr      <= '0;
        end else begin
            cdb_valid <= grant_fire;
            if (grant_fire) begin
                cdb_rob_tag <= fu_rob_tag[arb_idx];
                cdb_value   <= fu_value[arb_idx];
                cdb_fu_idx  <= arb_idx;
                rr_ptr      <= (arb_idx == IDX_W'(NUM_FU - 1)) ? '0 : arb_idx + IDX_W'(1);
            end
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic [NUM_FU-1:0][CNT_W-1:0] grant_cnt_q;
    logic [CNT_W-1:0]             conflict_q;
    logic                         multi_req;

    // More than one bit set iff clearing the lowest set bit leaves something.
    assign multi_req = (fu_req & (fu_req - NUM_FU'(1))) != '0;

    // Saturating per-FU grant totals and contention-cycle count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
            conflict_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_grant[i] && (grant_cnt_q[i] != '1))
                    grant_cnt_q[i] <= grant_cnt_q[i] + CNT_W'(1);
            end
            if (!squash && multi_req && (conflict_q != '1))
                conflict_q <= conflict_q + CNT_W'(1);
        end
    end

    assign grant_count    = grant_cnt_q;
    assign conflict_count = conflict_q;
`else
    assign grant_count    = '0;
    assign conflict_count = '0;
`endif

endmodule
